// File: rtl/tpu_driver.sv
// Host-side driver for the tpu convolution block: loads one frame of kernel and
// matrix words from an upstream stream, then buffers tpu results to a downstream stream.
module tpu_driver #(
    parameter int DATA_WIDTH   = 8,
    parameter int MATRIX_DIM   = 16,
    parameter int CONV_DIM     = 3,
    parameter int RESULT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  insert_kernal,
    output logic                  insert_matrix,
    output logic [DATA_WIDTH-1:0] tpu_data,
    output logic                  tpu_ready,
    input  logic                  tpu_done,
    input  logic [DATA_WIDTH-1:0] tpu_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam int K_WORDS     = CONV_DIM * CONV_DIM;
    localparam int M_WORDS     = MATRIX_DIM * MATRIX_DIM;
    localparam int RES_SIDE    = MATRIX_DIM - CONV_DIM + 1;
    localparam int NUM_RESULTS = RES_SIDE * RES_SIDE;
    localparam int LCW         = $clog2(M_WORDS + 1);
    localparam int RCW         = $clog2(NUM_RESULTS + 1);
    localparam int PW          = $clog2(RESULT_DEPTH);
    localparam int CW          = $clog2(RESULT_DEPTH + 1);

    localparam logic [LCW-1:0] K_LAST = LCW'(K_WORDS - 1);
    localparam logic [LCW-1:0] M_LAST = LCW'(M_WORDS - 1);
    localparam logic [RCW-1:0] R_LAST = RCW'(NUM_RESULTS - 1);
    localparam logic [CW-1:0]  FULL   = CW'(RESULT_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_M,
        COMPUTE,
        DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LCW-1:0]        r_load_cnt;
    logic [RCW-1:0]        r_res_cnt;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_mem [RESULT_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_load;
    logic w_accept;
    logic w_load_last;
    logic w_tpu_ready;
    logic w_push;
    logic w_pop;
    logic w_m_valid;

    always_comb begin
        w_load      = (r_state == LOAD_K) || (r_state == LOAD_M);
        w_accept    = w_load && s_valid;
        w_load_last = ((r_state == LOAD_K) && (r_load_cnt == K_LAST)) ||
                      ((r_state == LOAD_M) && (r_load_cnt == M_LAST));
        w_tpu_ready = (r_state == COMPUTE) && (r_count != FULL);
        w_push      = w_tpu_ready && tpu_done;
        w_m_valid   = (r_count != '0);
        w_pop       = w_m_valid && m_ready;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD_K;
            LOAD_K:  if (w_accept && w_load_last) w_next = LOAD_M;
            LOAD_M:  if (w_accept && w_load_last) w_next = COMPUTE;
            COMPUTE: if (w_push && (r_res_cnt == R_LAST)) w_next = DRAIN;
            DRAIN:   if (r_count == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_load_cnt   <= '0;
            r_res_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= (r_state == DRAIN) && (r_count == '0);
            if (r_state == IDLE)
                r_load_cnt <= '0;
            else if (w_accept)
                r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;
            if (r_state == IDLE)
                r_res_cnt <= '0;
            else if (w_push)
                r_res_cnt <= r_res_cnt + 1'b1;
        end
    end

    // Result FIFO: pointers wrap naturally since RESULT_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < RESULT_DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= tpu_result;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        busy          = (r_state != IDLE);
        frame_done    = r_frame_done;
        s_ready       = w_load;
        insert_kernal = (r_state == LOAD_K) && s_valid;
        insert_matrix = (r_state == LOAD_M) && s_valid;
        tpu_data      = w_accept ? s_data : '0;
        tpu_ready     = w_tpu_ready;
        m_valid       = w_m_valid;
        m_data        = r_mem[r_rd_ptr];
    end

endmodule

// File: tb/tb_tpu_driver.sv
// Directed self-checking bench for tpu_driver: load sequencing, result FIFO,
// backpressure, and reset abort, with a small bench-side FIFO/state model.
module tb_tpu_driver;

    localparam int NR = 196;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       insert_kernal;
    logic       insert_matrix;
    logic [7:0] tpu_data;
    logic       tpu_ready;
    logic       tpu_done = 1'b0;
    logic [7:0] tpu_result = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;

    int n_assert = 0;
    int n_fail   = 0;

    tpu_driver #(
        .DATA_WIDTH  (8),
        .MATRIX_DIM  (16),
        .CONV_DIM    (3),
        .RESULT_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .insert_kernal(insert_kernal),
        .insert_matrix(insert_matrix),
        .tpu_data     (tpu_data),
        .tpu_ready    (tpu_ready),
        .tpu_done     (tpu_done),
        .tpu_result   (tpu_result),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] word_of(input int idx);
        int t;
        t = (idx < 9) ? (32'hC0 + idx) : ((idx - 9) ^ 32'h3C);
        return 8'(t);
    endfunction

    // Drives start then the word stream; stops after stop_m matrix words when stop_m >= 0.
    task automatic do_load(input bit gaps, input int stop_m, output int nk, output int nm);
        int  idx;
        int  lim;
        bit  ph;
        logic [1:0] exp_s;
        lim = (stop_m >= 0) ? 9 + stop_m : 265;
        nk = 0; nm = 0; idx = 0; ph = 1'b1;
        @(negedge clk);
        start = 1'b1;
        #1;
        n_assert++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL load_idle_busy: got %b expected 0", busy); end
        @(negedge clk);
        start = 1'b0;
        while (idx < lim) begin
            s_valid = gaps ? ph : 1'b1;
            ph = !ph;
            s_data = word_of(idx);
            #1;
            n_assert++;
            if ({s_ready, tpu_ready, busy} !== 3'b101) begin
                n_fail++; $display("FAIL load_ctrl idx=%0d: got %b expected 101", idx, {s_ready, tpu_ready, busy});
            end
            exp_s = {s_valid && (idx < 9), s_valid && (idx >= 9)};
            n_assert++;
            if ({insert_kernal, insert_matrix} !== exp_s) begin
                n_fail++; $display("FAIL load_strobe idx=%0d: got %b expected %b", idx, {insert_kernal, insert_matrix}, exp_s);
            end
            if (s_valid) begin
                n_assert++;
                if (tpu_data !== s_data) begin
                    n_fail++; $display("FAIL load_data idx=%0d: got %0h expected %0h", idx, tpu_data, s_data);
                end
                idx++;
            end
            nk += int'(insert_kernal);
            nm += int'(insert_matrix);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // Runs COMPUTE/DRAIN against a FIFO model; tpu_done every `period` cycles,
    // m_ready held low until cycle release_cyc.
    task automatic do_results(input int period, input int release_cyc);
        int cap, outn, cnt, cyc, n_fd;
        bit drain, fd_exp, fin, push, pop;
        logic [3:0] exp_c;
        cap = 0; outn = 0; cnt = 0; cyc = 0; n_fd = 0;
        drain = 0; fd_exp = 0; fin = 0;
        while (!fin && cyc < 3000) begin
            tpu_done   = ((cyc % period) == period - 1);
            tpu_result = 8'(cap);
            m_ready    = (cyc >= release_cyc);
            start      = (cyc == 5);
            #1;
            exp_c = {!drain && (cnt < 4), cnt != 0, fd_exp, !fd_exp};
            n_assert++;
            if ({tpu_ready, m_valid, frame_done, busy} !== exp_c) begin
                n_fail++; $display("FAIL res_ctrl cyc=%0d: got %b expected %b", cyc, {tpu_ready, m_valid, frame_done, busy}, exp_c);
            end
            n_fd += int'(frame_done);
            if (cnt != 0 && m_ready) begin
                n_assert++;
                if (m_data !== 8'(outn)) begin
                    n_fail++; $display("FAIL res_data n=%0d: got %0h expected %0h", outn, m_data, 8'(outn));
                end
                outn++;
            end
            if (fd_exp) fin = 1'b1;
            else begin
                push   = tpu_done && !drain && (cnt < 4);
                pop    = (cnt != 0) && m_ready;
                fd_exp = drain && (cnt == 0);
                cnt    = cnt + int'(push) - int'(pop);
                if (push) begin
                    cap++;
                    if (cap == NR) drain = 1'b1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        tpu_done = 1'b0;
        start    = 1'b0;
        if (!fin) begin
            n_assert++; n_fail++;
            $display("FAIL res_timeout: got %0d outputs expected %0d", outn, NR);
        end
        #1;
        n_assert++;
        if ({frame_done, busy, m_valid} !== 3'b000) begin
            n_fail++; $display("FAIL res_after: got %b expected 000", {frame_done, busy, m_valid});
        end
        n_assert++;
        if (n_fd != 1) begin
            n_fail++; $display("FAIL res_frame_done_count: got %0d expected 1", n_fd);
        end
    endtask

    task automatic check_loaded(input string tag, input int nk, input int nm);
        n_assert++;
        if (nk != 9 || nm != 256) begin
            n_fail++; $display("FAIL %s_counts: got k=%0d m=%0d expected k=9 m=256", tag, nk, nm);
        end
        #1;
        n_assert++;
        if ({tpu_ready, s_ready, busy} !== 3'b101) begin
            n_fail++; $display("FAIL %s_compute_entry: got %b expected 101", tag, {tpu_ready, s_ready, busy});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_assert++;
        if ({busy, frame_done, m_valid, tpu_ready, s_ready, insert_kernal, insert_matrix} !== 7'b0 || m_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got %b/%0h expected 0000000/0",
                {busy, frame_done, m_valid, tpu_ready, s_ready, insert_kernal, insert_matrix}, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h55;
        repeat (4) begin
            @(negedge clk);
            #1;
            n_assert++;
            if ({busy, s_ready, insert_kernal, insert_matrix, tpu_ready} !== 5'b0) begin
                n_fail++; $display("FAIL idle_svalid: got %b expected 00000", {busy, s_ready, insert_kernal, insert_matrix, tpu_ready});
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_full_load();
        int nk, nm;
        do_load(1'b0, -1, nk, nm);
        check_loaded("full", nk, nm);
    endtask

    task automatic test_results();
        do_results(3, 0);
    endtask

    task automatic test_gaps();
        int nk, nm;
        do_load(1'b1, -1, nk, nm);
        check_loaded("gaps", nk, nm);
        do_results(1, 0);
    endtask

    task automatic test_backpressure();
        int nk, nm;
        do_load(1'b0, -1, nk, nm);
        check_loaded("bp", nk, nm);
        do_results(1, 12);
    endtask

    task automatic test_abort();
        int nk, nm;
        do_load(1'b0, 100, nk, nm);
        n_assert++;
        if (nk != 9 || nm != 100) begin
            n_fail++; $display("FAIL abort_partial: got k=%0d m=%0d expected k=9 m=100", nk, nm);
        end
        s_valid = 1'b1;
        rst = 1'b1;
        #1;
        n_assert++;
        if ({busy, s_ready, insert_matrix, m_valid, tpu_ready, frame_done} !== 6'b0) begin
            n_fail++; $display("FAIL abort_reset: got %b expected 000000", {busy, s_ready, insert_matrix, m_valid, tpu_ready, frame_done});
        end
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_assert++;
            if ({busy, frame_done, m_valid} !== 3'b000) begin
                n_fail++; $display("FAIL abort_idle: got %b expected 000", {busy, frame_done, m_valid});
            end
        end
        do_load(1'b0, -1, nk, nm);
        check_loaded("restart", nk, nm);
        do_results(2, 0);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_results();
        test_gaps();
        test_backpressure();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
